// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: one-pass sequencer (load, then ITER exec/wait pairs) for the 4-lane CORDIC process array.
// Optional CORDIC_SEQ_ABORT_EN adds an abort input and an aborted pulse output.
module cordic_seq_ctrl #(
  parameter int WIDTH_SHIFT_BIT = 4,
  parameter int ITER = 16,
  parameter int WIDTH_INDEX = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CORDIC_SEQ_ABORT_EN
  input  logic abort,
  output logic aborted,
`endif
  input  logic start,
  input  logic mode_rot,
  input  logic [WIDTH_INDEX-1:0] index_in,
  input  logic sign_fb,
  output logic ce,
  output logic sel,
  output logic [WIDTH_SHIFT_BIT-1:0] shift,
  output logic [WIDTH_SHIFT_BIT-1:0] count,
  output logic [WIDTH_INDEX-1:0] index,
  output logic sign_in,
  output logic sign_rotation,
  output logic [ITER-1:0] dir_word,
  output logic busy,
  output logic done
);
  typedef enum logic [2:0] {IDLE, LOAD, LWAIT, EXEC, WAIT, DONE} state_t;
  localparam logic [WIDTH_SHIFT_BIT-1:0] K_LAST = WIDTH_SHIFT_BIT'(ITER - 1);
  state_t state;
  logic [WIDTH_SHIFT_BIT-1:0] k;
  logic [WIDTH_SHIFT_BIT-1:0] kn;
  logic s;
  logic ab;
  assign kn = k + 1'b1;
`ifdef CORDIC_SEQ_ABORT_EN
  assign ab = abort && state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) aborted <= 1'b0;
    else aborted <= ab;
`else
  assign ab = 1'b0;
`endif
  // sign_in is registered on entry to EXEC, so vectoring uses sign_fb directly rather than s
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      s <= 1'b0;
      ce <= 1'b0;
      sel <= 1'b0;
      shift <= '0;
      count <= '0;
      index <= '0;
      sign_in <= 1'b0;
      sign_rotation <= 1'b0;
      dir_word <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ce <= 1'b0;
      sign_in <= 1'b0;
      done <= 1'b0;
      if (ab) begin
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= LOAD;
            sign_rotation <= mode_rot;
            index <= index_in;
            k <= '0;
            busy <= 1'b1;
            ce <= 1'b1;
            sel <= 1'b0;
            shift <= '0;
            count <= '0;
          end
          LOAD: state <= LWAIT;
          LWAIT: begin
            if (!sign_rotation) s <= sign_fb;
            state <= EXEC;
            ce <= 1'b1;
            sel <= 1'b1;
            shift <= k;
            count <= k;
            sign_in <= sign_rotation ? dir_word[k] : sign_fb;
          end
          EXEC: begin
            if (!sign_rotation) dir_word[k] <= s;
            state <= WAIT;
          end
          WAIT: begin
            if (!sign_rotation) s <= sign_fb;
            if (k == K_LAST) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              k <= kn;
              state <= EXEC;
              ce <= 1'b1;
              sel <= 1'b1;
              shift <= kn;
              count <= kn;
              sign_in <= sign_rotation ? dir_word[kn] : sign_fb;
            end
          end
          DONE: begin
            state <= IDLE;
            busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
